// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame parameters and
// the baud counter width helper, used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_STOP_BITS    = 1;
    localparam int UART_CLKS_PER_BIT = 1;

    function automatic int uart_cnt_width(input int clks);
        int w;
        w = $clog2(clks + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick on the last clock of every bit cell while
// run is high, and sits cleared while run is low.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int CW = uart_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 1) begin : g_bad_cpb
            $error("uart_baud_tick: CLKS_PER_BIT must be >= 1");
        end
    endgenerate

    logic [CW-1:0] count;

    // Gated by run so a 1-clock bit period does not tick while idle.
    assign tick = run && (count == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!run || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/ready handshake and shifts it
// out as start bit, LSB-first data bits and stop bits on a registered line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int STOP_BITS    = UART_STOP_BITS
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 done
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
            $error("uart_tx: DATA_BITS must be in 5..8");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
            $error("uart_tx: STOP_BITS must be in 1..2");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_cpb
            $error("uart_tx: CLKS_PER_BIT must be >= 1");
        end
    endgenerate

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e          state, state_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [2:0]           bit_cnt, bit_cnt_d;
    logic                 serial_d, done_d, tick, xfer;

    assign data_ready = (state == IDLE) && enable && reset_n;
    assign xfer       = data_valid && data_ready;
    assign busy       = (state != IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock  (clock),
        .reset_n(reset_n),
        .run    (busy),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_cnt_d = bit_cnt;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Line is registered from the next state so it changes on the same
        // edge as the state, e.g. low right after the accepting edge.
        serial_d = (state_d == DATA) ? shift_d[0] : (state_d != START);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            serial_out <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            shift      <= shift_d;
            bit_cnt    <= bit_cnt_d;
            serial_out <= serial_d;
            done       <= done_d;
        end
    end

endmodule
